// File: rtl/operand_entry.sv
// operand_entry: sequential operand/op-code entry front end.
//   Collects m, n (4 bits each) and choose (3 bits) from the switches one
//   field at a time. btn_next latches the current field and advances;
//   btn_back steps back one field. start pulses for one cycle on the final
//   latch.
// Build option: `OPERAND_ENTRY_DEBOUNCE_EN enables the button debouncers.
//   When it is undefined, the debounced level is the synchronized level.
// Ports:
//   clk, rst               clock, async active-high reset
//   sw[3:0]                raw switches (asynchronous)
//   btn_next, btn_back     raw push-buttons (asynchronous, active-high)
//   m, n, choose           stored operands / operation code
//   start                  one-cycle pulse when entry completes
//   entry_done             high while in S_SHOW
//   stage, stage_led       current field (binary / one-hot)
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_back,
  output logic [3:0] m,
  output logic [3:0] n,
  output logic [2:0] choose,
  output logic       start,
  output logic       entry_done,
  output logic [1:0] stage,
  output logic [3:0] stage_led
);

  typedef enum logic [1:0] {
    S_M    = 2'd0,
    S_N    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  // Button vectors: bit 0 = next, bit 1 = back
  logic [3:0] r_sw_s1, r_sw_s2;
  logic [1:0] r_btn_s1, r_btn_s2;
  logic [1:0] w_btn_deb;
  logic [1:0] r_btn_prev;
  logic [1:0] w_rise;
  logic       w_evt_next, w_evt_back;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= {btn_back, btn_next};
      r_btn_s2 <= r_btn_s1;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    r_btn_deb;
  logic [CW-1:0] r_cnt [2];

  // Count while synced and debounced levels disagree; accept the new level
  // after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_deb <= '0;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_btn_s2[i] != r_btn_deb[i]) begin
          if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_btn_deb[i] <= r_btn_s2[i];
            r_cnt[i]     <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_btn_deb = r_btn_deb;
`else
  assign w_btn_deb = r_btn_s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn_prev <= '0;
    else     r_btn_prev <= w_btn_deb;
  end

  // Rising edges only; simultaneous presses cancel each other.
  assign w_rise     = w_btn_deb & ~r_btn_prev;
  assign w_evt_next = w_rise[0] & ~w_rise[1];
  assign w_evt_back = w_rise[1] & ~w_rise[0];

  state_t     r_state, w_state_nx;
  logic       w_ld_m, w_ld_n, w_ld_c, w_start_nx;
  logic [3:0] r_m, r_n;
  logic [2:0] r_choose;
  logic       r_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_M;
      r_m      <= '0;
      r_n      <= '0;
      r_choose <= '0;
      r_start  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_start <= w_start_nx;
      if (w_ld_m) r_m      <= r_sw_s2;
      if (w_ld_n) r_n      <= r_sw_s2;
      if (w_ld_c) r_choose <= r_sw_s2[2:0];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ld_m     = 1'b0;
    w_ld_n     = 1'b0;
    w_ld_c     = 1'b0;
    w_start_nx = 1'b0;
    case (r_state)
      S_M: begin
        if (w_evt_next) begin
          w_ld_m     = 1'b1;
          w_state_nx = S_N;
        end
      end
      S_N: begin
        if (w_evt_next) begin
          w_ld_n     = 1'b1;
          w_state_nx = S_OP;
        end else if (w_evt_back) begin
          w_state_nx = S_M;
        end
      end
      S_OP: begin
        if (w_evt_next) begin
          w_ld_c     = 1'b1;
          w_start_nx = 1'b1;
          w_state_nx = S_SHOW;
        end else if (w_evt_back) begin
          w_state_nx = S_N;
        end
      end
      S_SHOW: begin
        if (w_evt_next)      w_state_nx = S_M;
        else if (w_evt_back) w_state_nx = S_OP;
      end
      default: w_state_nx = S_M;
    endcase
  end

  assign m          = r_m;
  assign n          = r_n;
  assign choose     = r_choose;
  assign start      = r_start;
  assign stage      = r_state;
  assign entry_done = (r_state == S_SHOW);
  assign stage_led  = 4'b0001 << r_state;

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;
  localparam int DC = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int LAT = DC + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic       btn_next = 1'b0;
  logic       btn_back = 1'b0;
  logic [3:0] m, n, stage_led;
  logic [2:0] choose;
  logic       start, entry_done;
  logic [1:0] stage;

  operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_back(btn_back),
    .m(m), .n(n), .choose(choose), .start(start), .entry_done(entry_done),
    .stage(stage), .stage_led(stage_led)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int start_cnt = 0;
  int bad_start = 0;
  logic start_prev = 1'b0;

  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      if (stage != 2'd3) bad_start++;
      if (start_prev) bad_start++;
    end
    start_prev = start;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int s, input int em,
                            input int en, input int ec);
    check({tag, " stage"}, stage, s);
    check({tag, " stage_led"}, stage_led, 1 << s);
    check({tag, " entry_done"}, entry_done, (s == 3) ? 1 : 0);
    check({tag, " m"}, m, em);
    check({tag, " n"}, n, en);
    check({tag, " choose"}, choose, ec);
  endtask

  // Raise btn_next just after an edge, return the edge index at which stage
  // first changes (0 if it never does within the budget).
  task automatic measure_next(input int hold, output int hit, output int changes);
    logic [1:0] prev;
    hit = 0;
    changes = 0;
    prev = stage;
    btn_next = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (k == 1 && hold == 1) btn_next = 1'b0;
      if (stage != prev) begin
        if (hit == 0) hit = k;
        changes++;
        prev = stage;
      end
    end
    btn_next = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk);
      #1;
      if (stage != prev) begin
        changes++;
        prev = stage;
      end
    end
  endtask

  typedef struct {
    logic [3:0] sw;
    logic       nx;
    logic       bk;
    int         stg;
    logic [3:0] m;
    logic [3:0] n;
    logic [2:0] c;
    int         st;
  } vec_t;

  vec_t vt [17];
  int   exp_starts;
  int   hit, changes;

  initial begin
    vt[0]  = '{4'hA, 1'b1, 1'b0, 1, 4'hA, 4'h0, 3'd0, 0};
    vt[1]  = '{4'h3, 1'b1, 1'b0, 2, 4'hA, 4'h3, 3'd0, 0};
    vt[2]  = '{4'h5, 1'b1, 1'b0, 3, 4'hA, 4'h3, 3'd5, 1};
    vt[3]  = '{4'hF, 1'b1, 1'b0, 0, 4'hA, 4'h3, 3'd5, 0};
    vt[4]  = '{4'h7, 1'b0, 1'b1, 0, 4'hA, 4'h3, 3'd5, 0};
    vt[5]  = '{4'h7, 1'b1, 1'b0, 1, 4'h7, 4'h3, 3'd5, 0};
    vt[6]  = '{4'h1, 1'b1, 1'b1, 1, 4'h7, 4'h3, 3'd5, 0};
    vt[7]  = '{4'h2, 1'b0, 1'b1, 0, 4'h7, 4'h3, 3'd5, 0};
    vt[8]  = '{4'h9, 1'b1, 1'b0, 1, 4'h9, 4'h3, 3'd5, 0};
    vt[9]  = '{4'h4, 1'b1, 1'b0, 2, 4'h9, 4'h4, 3'd5, 0};
    vt[10] = '{4'hE, 1'b0, 1'b1, 1, 4'h9, 4'h4, 3'd5, 0};
    vt[11] = '{4'hE, 1'b0, 1'b1, 0, 4'h9, 4'h4, 3'd5, 0};
    vt[12] = '{4'h6, 1'b1, 1'b0, 1, 4'h6, 4'h4, 3'd5, 0};
    vt[13] = '{4'h6, 1'b1, 1'b0, 2, 4'h6, 4'h6, 3'd5, 0};
    vt[14] = '{4'h2, 1'b1, 1'b0, 3, 4'h6, 4'h6, 3'd2, 1};
    vt[15] = '{4'h0, 1'b0, 1'b1, 2, 4'h6, 4'h6, 3'd2, 0};
    vt[16] = '{4'hB, 1'b1, 1'b0, 3, 4'h6, 4'h6, 3'd3, 1};

    // Reset and idle
    cyc(3);
    #1 rst = 1'b0;
    cyc(12);
    check_outs("reset", 0, 0, 0, 0);
    check("reset start_cnt", start_cnt, 0);

    // Press latency from S_M
    sw = 4'hC;
    cyc(3);
    measure_next(LAT + 4, hit, changes);
    check("latency edge", hit, LAT);
    check("latency one event", changes, 1);
    check_outs("after latency", 1, 4'hC, 0, 0);

    sw = 4'h5;
    cyc(3);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    // Bounce: three 3-cycle pulses, then a 20-cycle hold
    for (int p = 0; p < 3; p++) begin
      btn_next = 1'b1;
      cyc(3);
      btn_next = 1'b0;
      cyc(3);
    end
    check("bounce absorbed", stage, 1);
    measure_next(20, hit, changes);
    check("bounce edge", hit, 7);
    check("bounce one event", changes, 1);
`else
    // Single-cycle clean press
    measure_next(1, hit, changes);
    if (hit == 0) begin
      for (int k = 0; k < 0; k++) ;
    end
    check("short press one event", changes, 1);
`endif
    check_outs("in S_OP", 2, 4'hC, 4'h5, 0);

    // Asynchronous reset mid-entry
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_outs("async reset", 0, 0, 0, 0);
    check("async reset start", start, 0);
    cyc(3);
    #1 rst = 1'b0;
    cyc(3);

    // Table-driven entry / navigation
    exp_starts = start_cnt;
    for (int i = 0; i < 17; i++) begin
      sw = vt[i].sw;
      cyc(3);
      btn_next = vt[i].nx;
      btn_back = vt[i].bk;
      cyc(LAT + 2);
      btn_next = 1'b0;
      btn_back = 1'b0;
      cyc(LAT + 3);
      exp_starts += vt[i].st;
      check_outs($sformatf("vec%0d", i), vt[i].stg, vt[i].m, vt[i].n, vt[i].c);
      check($sformatf("vec%0d start_cnt", i), start_cnt, exp_starts);
    end
    check("start pulse shape", bad_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
